// File: rtl/double_tokens_if.sv
// Token-stream bundle for double_tokens: the producer drives a, the multiplier
// returns b plus its pending/overflow status.
interface double_tokens_if #(
    parameter int unsigned PENDING_W = 4
);
    logic                 a;
    logic                 b;
    logic                 busy;
    logic [PENDING_W-1:0] pending;
    logic                 overflow;

    modport master (output a, input b, busy, pending, overflow);
    modport slave  (input a, output b, busy, pending, overflow);
endinterface

// File: rtl/double_tokens.sv
// Serial token multiplier: each '1' on a becomes FACTOR '1's on b, at most one
// per cycle, with surplus tokens held in a saturating pending counter.
module double_tokens #(
    parameter int unsigned FACTOR    = 2,
    parameter int unsigned PENDING_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    double_tokens_if.slave tok
);
    localparam int unsigned MAX_P = (2 ** PENDING_W) - 1;
    localparam int unsigned SUM_W = PENDING_W + 2;

    logic [PENDING_W-1:0] p_q, p_d;
    logic                 ovf_q, ovf_d;
    logic                 b_c;
    logic [SUM_W-1:0]     sum_c;

    // b is Mealy on a so the first token of each input goes out with no latency
    always_comb begin
        p_d   = p_q;
        ovf_d = ovf_q;
        b_c   = ~rst & (tok.a | (p_q != '0));
        sum_c = SUM_W'(p_q)
              + (tok.a ? SUM_W'(FACTOR) : SUM_W'(0))
              - (b_c   ? SUM_W'(1)      : SUM_W'(0));
        if (sum_c > SUM_W'(MAX_P)) begin
            p_d   = PENDING_W'(MAX_P);
            ovf_d = 1'b1;
        end else begin
            p_d   = sum_c[PENDING_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            ovf_q <= ovf_d;
        end
    end

    assign tok.b        = b_c;
    assign tok.busy     = (p_q != '0);
    assign tok.pending  = p_q;
    assign tok.overflow = ovf_q;
endmodule

// File: tb/tb_double_tokens.sv
// Directed bench for double_tokens: vector table for FACTOR=2 plus hand-written
// saturation and FACTOR=3 sequences.
module tb_double_tokens;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    double_tokens_if #(.PENDING_W(4)) t2 ();
    double_tokens_if #(.PENDING_W(4)) t3 ();

    double_tokens #(.FACTOR(2), .PENDING_W(4)) dut2 (.clk(clk), .rst(rst), .tok(t2.slave));
    double_tokens #(.FACTOR(3), .PENDING_W(4)) dut3 (.clk(clk), .rst(rst), .tok(t3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       a;
        logic       b;     // expected b during the cycle
        logic [3:0] p;     // expected pending after the edge
        logic       ovf;   // expected overflow after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle on the selected instance; b checked before the edge, state after.
    task automatic step(input bit sel3, input logic r, input logic av, input logic eb,
                        input int ep, input logic eovf, input string tag);
        rst = r;
        if (sel3) t3.a = av; else t2.a = av;
        #2;
        check({tag, " b"}, int'(sel3 ? t3.b : t2.b), int'(eb));
        @(posedge clk);
        #1;
        check({tag, " pending"}, int'(sel3 ? t3.pending : t2.pending), ep);
        check({tag, " busy"}, int'(sel3 ? t3.busy : t2.busy), int'(ep != 0));
        check({tag, " overflow"}, int'(sel3 ? t3.overflow : t2.overflow), int'(eovf));
    endtask

    function automatic vec_t mk(input logic r, input logic av, input logic eb,
                                input int ep, input logic eovf);
        vec_t v;
        v.rst = r;
        v.a   = av;
        v.b   = eb;
        v.p   = 4'(ep);
        v.ovf = eovf;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        t2.a = 1'b0;
        t3.a = 1'b0;
        @(posedge clk);
        #1;

        // reset held with a=1, then release
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        // single token
        vecs.push_back(mk(0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        // pattern 110011
        vecs.push_back(mk(0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        // build pending=5, reset mid-operation, restart
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 1, 1, i, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0));

        foreach (vecs[i])
            step(1'b0, vecs[i].rst, vecs[i].a, vecs[i].b, int'(vecs[i].p), vecs[i].ovf,
                 $sformatf("vec%0d", i));

        // saturation: 20 cycles of a=1, clamp and sticky overflow on the 16th edge
        for (int i = 1; i <= 20; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, (i < 15) ? i : 15, i >= 16, $sformatf("sat_in%0d", i));
        for (int i = 1; i <= 15; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 15 - i, 1'b1, $sformatf("sat_drain%0d", i));
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, "sat_idle0");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, "sat_idle1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, "sat_rst");

        // FACTOR=3: single pulse
        step(1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, "f3_single0");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, "f3_single1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, "f3_single2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "f3_single3");
        // FACTOR=3: two back-to-back pulses give six consecutive b ones
        step(1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, "f3_pair0");
        step(1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0, "f3_pair1");
        for (int i = 2; i <= 5; i++)
            step(1'b1, 1'b0, 1'b0, 1'b1, 5 - i, 1'b0, $sformatf("f3_pair%0d", i));
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "f3_pair6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
